detect_winner: RTL and testbench

DETECT_WINNER -- requirements
Module: detect_winner

---
 rtl/detect_winner.sv | 67 ++++++
 tb/tb_detect_winner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/detect_winner.sv
// 4x4 win/draw detector: evaluates all ten lines each cycle and latches the first
// non-zero result until reset.
module detect_winner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] game_board,
  input  logic [15:0] player_cells,
  output logic [1:0]  game_status
);

  typedef enum logic [1:0] {
    StPlaying = 2'b00,
    StP1Win   = 2'b01,
    StP2Win   = 2'b10,
    StDraw    = 2'b11
  } status_e;

  localparam int unsigned NumLines = 10;

  // Four rows, four columns, main diagonal, anti-diagonal.
  localparam logic [15:0] LineMask [NumLines] = '{
    16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
    16'h1111, 16'h2222, 16'h4444, 16'h8888,
    16'h8421, 16'h1248
  };

  status_e     status_q, status_d;
  logic [15:0] p1_cells, p2_cells;
  logic        p1_win, p2_win, board_full;

  // Owner bits only count where the cell is occupied.
  assign p1_cells   = game_board & ~player_cells;
  assign p2_cells   = game_board & player_cells;
  assign board_full = (game_board == 16'hFFFF);

  always_comb begin
    p1_win = 1'b0;
    p2_win = 1'b0;
    for (int l = 0; l < NumLines; l++) begin
      p1_win = p1_win | ((p1_cells & LineMask[l]) == LineMask[l]);
      p2_win = p2_win | ((p2_cells & LineMask[l]) == LineMask[l]);
    end
  end

  // A win outranks a full board, and player 1 outranks player 2.
  always_comb begin
    status_d = StPlaying;
    if (p1_win) begin
      status_d = StP1Win;
    end else if (p2_win) begin
      status_d = StP2Win;
    end else if (board_full) begin
      status_d = StDraw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= StPlaying;
    end else if (status_q == StPlaying) begin
      status_q <= status_d;
    end
  end

  assign game_status = status_q;

endmodule

// File: tb/tb_detect_winner.sv
// Self-checking bench for detect_winner: table of single-board vectors plus
// hand-written sequences for build-up, stickiness and asynchronous reset.
module tb_detect_winner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] game_board = 16'h0000;
  logic [15:0] player_cells = 16'h0000;
  logic [1:0]  game_status;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [1:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sb[$];

  typedef struct {
    logic [15:0] board;
    logic [15:0] cells;
    logic [1:0]  exp;
    string       name;
  } vec_t;

  detect_winner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_board   (game_board),
    .player_cells (player_cells),
    .game_status  (game_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: game_status=%b expected=%b", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive inputs, queue the expectation, compare just after the next rising edge.
  task automatic step(input logic [15:0] board, input logic [15:0] cells,
                      input logic [1:0] exp, input string name);
    sb_entry_t e;
    game_board   = board;
    player_cells = cells;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, game_status=%b", name, game_status);
    end else begin
      e = sb.pop_front();
      check(e.name, game_status, e.exp);
    end
  endtask

  // Called #1 after a rising edge; releases reset before the following edge.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check(name, game_status, 2'b00);
    game_board   = 16'h0000;
    player_cells = 16'h0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, game_status=%b", game_status);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    vecs.push_back('{16'h0000, 16'h0000, 2'b00, "empty_board"});
    vecs.push_back('{16'h000F, 16'h0000, 2'b01, "row0_p1"});
    vecs.push_back('{16'h000F, 16'hFFF0, 2'b01, "row0_p1_ignored_bits"});
    vecs.push_back('{16'hF000, 16'hF000, 2'b10, "row3_p2"});
    vecs.push_back('{16'h2222, 16'h2222, 2'b10, "col1_p2"});
    vecs.push_back('{16'h1111, 16'h0000, 2'b01, "col0_p1"});
    vecs.push_back('{16'h8421, 16'h8421, 2'b10, "diag_p2"});
    vecs.push_back('{16'h1248, 16'h0000, 2'b01, "antidiag_p1"});
    vecs.push_back('{16'h0007, 16'hFFFF, 2'b00, "partial_ignored"});
    vecs.push_back('{16'h000E, 16'h0001, 2'b00, "row0_gap"});
    vecs.push_back('{16'hFFFF, 16'hC3C3, 2'b11, "draw"});
    vecs.push_back('{16'hFFFF, 16'h936C, 2'b10, "full_antidiag_p2"});
    vecs.push_back('{16'hFFFF, 16'h00FF, 2'b01, "both_win_p1_priority"});
    vecs.push_back('{16'hFFFF, 16'h0000, 2'b01, "full_board_win"});

    // Power-on reset.
    @(posedge clk);
    #1;
    do_reset("reset_initial");

    foreach (vecs[i]) begin
      step(vecs[i].board, vecs[i].cells, vecs[i].exp, vecs[i].name);
      do_reset("reset_between");
    end

    // Row build-up: P1 on 1,2,0,3 interleaved with P2 on 5,6,4.
    step(16'h0002, 16'h0000, 2'b00, "build_c1");
    step(16'h0022, 16'h0020, 2'b00, "build_c5");
    step(16'h0026, 16'h0020, 2'b00, "build_c2");
    step(16'h0066, 16'h0060, 2'b00, "build_c6");
    step(16'h0067, 16'h0060, 2'b00, "build_c0");
    step(16'h0077, 16'h0070, 2'b00, "build_c4");
    // No combinational path to the output: still 00 before the edge.
    game_board = 16'h007F;
    #1;
    check("latency_before_edge", game_status, 2'b00);
    step(16'h007F, 16'h0070, 2'b01, "build_c3_win");
    step(16'h007F, 16'h0070, 2'b01, "win_held");

    // Sticky through a cleared board and a competing P2 line.
    step(16'h0000, 16'h0000, 2'b01, "sticky_cleared");
    step(16'hF000, 16'hF000, 2'b01, "sticky_vs_p2");

    // Mid-cycle asynchronous reset, held across edges with a winning board.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", game_status, 2'b00);
    game_board   = 16'h000F;
    player_cells = 16'h0000;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("held_in_reset", game_status, 2'b00);
    end
    game_board = 16'h0000;
    rst_n = 1'b1;
    step(16'h0000, 16'h0000, 2'b00, "empty_after_reset");
    step(16'h0000, 16'h0000, 2'b00, "empty_after_reset2");
    step(16'h8888, 16'h8888, 2'b10, "resume_col3_p2");
    step(16'h000F, 16'h0000, 2'b10, "sticky_p2_vs_p1");

    // Draw is sticky too, and cleared by reset.
    do_reset("reset_before_draw");
    step(16'hFFFF, 16'hC3C3, 2'b11, "draw_seq");
    step(16'h0000, 16'h0000, 2'b11, "draw_sticky");
    do_reset("reset_clears_draw");
    step(16'h0000, 16'h0000, 2'b00, "post_draw_reset");

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
